// File: rtl/ntm_modular_multiplier_arbiter.sv
// ntm_modular_multiplier_arbiter
//
// Purpose: shares one iterative modular multiplier (result = A*B mod X, with a
// START/READY handshake) among REQUESTERS clients. A round-robin pointer picks
// the next client. The winner's operands are latched and the multiplier is
// started. The result is returned with a one-cycle DONE strobe to that client.
//
// Ports:
//   CLK          rising-edge clock
//   RST          asynchronous active-high reset (shared with the multiplier)
//   REQ_IN       per-client request level
//   GNT_OUT      registered one-hot grant
//   DONE_OUT     one-cycle completion strobe to the granted client
//   ERROR_OUT    valid with DONE: operation rejected because X was zero
//   DATA_A_IN    packed client A operands, client i at [i*DATA_SIZE +: DATA_SIZE]
//   DATA_B_IN    packed client B operands, same packing
//   DATA_X_IN    packed client moduli, same packing
//   DATA_OUT     result, valid with DONE, holds otherwise
//   MUL_START    start pulse to the multiplier
//   MUL_READY    multiplier done pulse
//   MUL_DATA_A   latched A to the multiplier
//   MUL_DATA_B   latched B to the multiplier
//   MUL_DATA_X   latched X to the multiplier
//   MUL_DATA_IN  multiplier result
module ntm_modular_multiplier_arbiter #(
  parameter int DATA_SIZE  = 64,
  parameter int REQUESTERS = 4,
  parameter int INDEX_SIZE = $clog2(REQUESTERS)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [REQUESTERS-1:0]            REQ_IN,
  output logic [REQUESTERS-1:0]            GNT_OUT,
  output logic [REQUESTERS-1:0]            DONE_OUT,
  output logic                             ERROR_OUT,
  input  logic [REQUESTERS*DATA_SIZE-1:0]  DATA_A_IN,
  input  logic [REQUESTERS*DATA_SIZE-1:0]  DATA_B_IN,
  input  logic [REQUESTERS*DATA_SIZE-1:0]  DATA_X_IN,
  output logic [DATA_SIZE-1:0]             DATA_OUT,
  output logic                             MUL_START,
  input  logic                             MUL_READY,
  output logic [DATA_SIZE-1:0]             MUL_DATA_A,
  output logic [DATA_SIZE-1:0]             MUL_DATA_B,
  output logic [DATA_SIZE-1:0]             MUL_DATA_X,
  input  logic [DATA_SIZE-1:0]             MUL_DATA_IN
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  state_t                 r_state, w_stateNext;
  logic [INDEX_SIZE-1:0]  r_ptr, w_ptrNext;
  logic [INDEX_SIZE-1:0]  r_idx, w_idxNext;
  logic [REQUESTERS-1:0]  r_gnt, w_gntNext;
  logic [REQUESTERS-1:0]  r_done, w_doneNext;
  logic                   r_error, w_errorNext;
  logic [DATA_SIZE-1:0]   r_data, w_dataNext;
  logic                   r_start, w_startNext;
  logic [DATA_SIZE-1:0]   r_mulA, w_mulANext;
  logic [DATA_SIZE-1:0]   r_mulB, w_mulBNext;
  logic [DATA_SIZE-1:0]   r_mulX, w_mulXNext;

  logic                   w_found;
  logic [INDEX_SIZE-1:0]  w_win;
  logic [INDEX_SIZE:0]    w_cand;
  logic [DATA_SIZE-1:0]   w_selA, w_selB, w_selX;
  logic [REQUESTERS-1:0]  w_winOneHot;
  logic [INDEX_SIZE-1:0]  w_ptrInc;

  // Round-robin search: walk the clients starting at the pointer, wrapping
  // modulo REQUESTERS. The candidate carries one extra bit so the wrap works
  // for non-power-of-two client counts.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      w_cand = {1'b0, r_ptr} + (INDEX_SIZE+1)'(i);
      if (w_cand >= (INDEX_SIZE+1)'(REQUESTERS))
        w_cand = w_cand - (INDEX_SIZE+1)'(REQUESTERS);
      if (!w_found && REQ_IN[w_cand[INDEX_SIZE-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[INDEX_SIZE-1:0];
      end
    end
  end

  assign w_selA      = DATA_A_IN[int'(w_win)*DATA_SIZE +: DATA_SIZE];
  assign w_selB      = DATA_B_IN[int'(w_win)*DATA_SIZE +: DATA_SIZE];
  assign w_selX      = DATA_X_IN[int'(w_win)*DATA_SIZE +: DATA_SIZE];
  assign w_winOneHot = REQUESTERS'(1) << w_win;
  assign w_ptrInc    = (r_idx == INDEX_SIZE'(REQUESTERS-1)) ? '0 : r_idx + INDEX_SIZE'(1);

  // Next-state and next-output logic. Every output is a register, so entering
  // a state sets that state's outputs: MUL_START is high during ISSUE, and
  // DONE/DATA/ERROR are valid during RESPOND. A zero modulus skips the
  // multiplier entirely, because it would never signal READY.
  always_comb begin
    w_stateNext = r_state;
    w_ptrNext   = r_ptr;
    w_idxNext   = r_idx;
    w_gntNext   = r_gnt;
    w_doneNext  = r_done;
    w_errorNext = r_error;
    w_dataNext  = r_data;
    w_startNext = 1'b0;
    w_mulANext  = r_mulA;
    w_mulBNext  = r_mulB;
    w_mulXNext  = r_mulX;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_gntNext  = w_winOneHot;
          w_idxNext  = w_win;
          w_mulANext = w_selA;
          w_mulBNext = w_selB;
          w_mulXNext = w_selX;
          if (w_selX == '0) begin
            w_errorNext = 1'b1;
            w_dataNext  = '0;
            w_doneNext  = w_winOneHot;
            w_stateNext = ST_RESPOND;
          end else begin
            w_startNext = 1'b1;
            w_stateNext = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        w_stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        // A client that dropped its request still gets DATA_OUT updated,
        // but its DONE strobe is suppressed.
        if (MUL_READY) begin
          w_dataNext  = MUL_DATA_IN;
          w_errorNext = 1'b0;
          w_doneNext  = r_gnt & REQ_IN;
          w_stateNext = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        w_doneNext  = '0;
        w_gntNext   = '0;
        w_ptrNext   = w_ptrInc;
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_error <= 1'b0;
      r_data  <= '0;
      r_start <= 1'b0;
      r_mulA  <= '0;
      r_mulB  <= '0;
      r_mulX  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
      r_idx   <= w_idxNext;
      r_gnt   <= w_gntNext;
      r_done  <= w_doneNext;
      r_error <= w_errorNext;
      r_data  <= w_dataNext;
      r_start <= w_startNext;
      r_mulA  <= w_mulANext;
      r_mulB  <= w_mulBNext;
      r_mulX  <= w_mulXNext;
    end
  end

  assign GNT_OUT    = r_gnt;
  assign DONE_OUT   = r_done;
  assign ERROR_OUT  = r_error;
  assign DATA_OUT   = r_data;
  assign MUL_START  = r_start;
  assign MUL_DATA_A = r_mulA;
  assign MUL_DATA_B = r_mulB;
  assign MUL_DATA_X = r_mulX;

endmodule

// File: tb/tb_ntm_modular_multiplier_arbiter.sv
// tb_ntm_modular_multiplier_arbiter
//
// Purpose: self-checking bench for ntm_modular_multiplier_arbiter. A
// behavioural modular multiplier with a programmable latency answers the
// START pulses. Expected completions go into a scoreboard queue when a
// request is raised. They are popped and compared whenever DONE_OUT strobes.
//
// Ports: none (top-level bench).
module tb_ntm_modular_multiplier_arbiter;

  localparam int DW = 64;
  localparam int NR = 4;

  logic               CLK;
  logic               RST;
  logic [NR-1:0]      REQ_IN;
  logic [NR-1:0]      GNT_OUT;
  logic [NR-1:0]      DONE_OUT;
  logic               ERROR_OUT;
  logic [NR*DW-1:0]   DATA_A_IN, DATA_B_IN, DATA_X_IN;
  logic [DW-1:0]      DATA_OUT;
  logic               MUL_START;
  logic               MUL_READY;
  logic [DW-1:0]      MUL_DATA_A, MUL_DATA_B, MUL_DATA_X;
  logic [DW-1:0]      MUL_DATA_IN;

  typedef struct {
    int           client;
    logic [DW-1:0] data;
    logic         err;
  } exp_t;

  typedef struct {
    int           client;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] x;
    logic [DW-1:0] expData;
    logic         expErr;
    int           lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  int assertCount = 0;
  int failCount   = 0;
  int startCount  = 0;
  int mulLatency  = 0;
  bit autoDrop    = 1'b1;
  bit forceReady  = 1'b0;
  bit prevStart   = 1'b0;

  ntm_modular_multiplier_arbiter #(
    .DATA_SIZE  (DW),
    .REQUESTERS (NR)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ_IN      (REQ_IN),
    .GNT_OUT     (GNT_OUT),
    .DONE_OUT    (DONE_OUT),
    .ERROR_OUT   (ERROR_OUT),
    .DATA_A_IN   (DATA_A_IN),
    .DATA_B_IN   (DATA_B_IN),
    .DATA_X_IN   (DATA_X_IN),
    .DATA_OUT    (DATA_OUT),
    .MUL_START   (MUL_START),
    .MUL_READY   (MUL_READY),
    .MUL_DATA_A  (MUL_DATA_A),
    .MUL_DATA_B  (MUL_DATA_B),
    .MUL_DATA_X  (MUL_DATA_X),
    .MUL_DATA_IN (MUL_DATA_IN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: samples START on the falling edge, counts
  // mulLatency cycles, then pulses READY with A*B mod X for one cycle.
  initial begin
    bit             mulBusy;
    int             mulCnt;
    logic [DW-1:0]  mulRes, mulX;
    logic [2*DW-1:0] prod;
    mulBusy     = 1'b0;
    mulCnt      = 0;
    mulRes      = '0;
    mulX        = '0;
    MUL_READY   = 1'b0;
    MUL_DATA_IN = '0;
    forever begin
      @(negedge CLK);
      MUL_READY = 1'b0;
      if (RST) begin
        mulBusy = 1'b0;
      end else if (forceReady) begin
        MUL_READY   = 1'b1;
        MUL_DATA_IN = 64'hDEAD_BEEF_0BAD_F00D;
        forceReady  = 1'b0;
      end else if (mulBusy) begin
        if (mulCnt == 0) begin
          checkOutput("mulXStable", MUL_DATA_X, mulX);
          MUL_READY   = 1'b1;
          MUL_DATA_IN = mulRes;
          mulBusy     = 1'b0;
        end else begin
          mulCnt--;
        end
      end else if (MUL_START) begin
        mulBusy = 1'b1;
        mulCnt  = mulLatency;
        mulX    = MUL_DATA_X;
        prod    = {{DW{1'b0}}, MUL_DATA_A} * {{DW{1'b0}}, MUL_DATA_B};
        mulRes  = (MUL_DATA_X == '0) ? '0 : DW'(prod % {{DW{1'b0}}, MUL_DATA_X});
      end
    end
  end

  // START pulse counter; a START high on two consecutive cycles is an error.
  always @(negedge CLK) begin
    if (MUL_START) begin
      startCount++;
      checkOutput("startSingleCycle", {63'd0, prevStart}, 64'd0);
    end
    prevStart = MUL_START;
  end

  // Completion monitor: every DONE strobe must match the scoreboard head.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && DONE_OUT != '0) begin
      if (sb.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpectedDone: got DONE_OUT=%b, expected none", DONE_OUT);
      end else begin
        e = sb.pop_front();
        checkOutput("doneClient", DW'(DONE_OUT), DW'(NR'(1) << e.client));
        checkOutput("gntWithDone", DW'(GNT_OUT), DW'(NR'(1) << e.client));
        checkOutput("dataOut", DATA_OUT, e.data);
        checkOutput("errorOut", DW'(ERROR_OUT), DW'(e.err));
      end
      if (autoDrop) REQ_IN = REQ_IN & ~DONE_OUT;
    end
  end

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    DATA_A_IN[v.client*DW +: DW] = v.a;
    DATA_B_IN[v.client*DW +: DW] = v.b;
    DATA_X_IN[v.client*DW +: DW] = v.x;
    mulLatency = v.lat;
    e.client = v.client;
    e.data   = v.expData;
    e.err    = v.expErr;
    sb.push_back(e);
    REQ_IN[v.client] = 1'b1;
  endtask

  task automatic waitDrain(input string name, input int budget, output int used);
    used = 0;
    while (sb.size() != 0 && used < budget) begin
      @(negedge CLK);
      #1;
      used++;
    end
    if (sb.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: timeout with %0d completions pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic waitStart(input string name, input int budget);
    int used = 0;
    while (!MUL_START && used < budget) begin
      @(negedge CLK);
      used++;
    end
    if (!MUL_START) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: MUL_START=0 after %0d cycles, expected 1", name, used);
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST    = 1'b1;
    REQ_IN = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  function automatic vec_t mkVec(int c, logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] x,
                                 logic [DW-1:0] d, logic er, int lat);
    vec_t v;
    v.client = c; v.a = a; v.b = b; v.x = x; v.expData = d; v.expErr = er; v.lat = lat;
    return v;
  endfunction

  initial begin
    int used;
    int startBefore;
    int waited;

    vecs[0] = mkVec(0, 64'd7, 64'd5, 64'd11, 64'd2, 1'b0, 0);
    vecs[1] = mkVec(1, 64'd9, 64'd9, 64'd0, 64'd0, 1'b1, 1);
    vecs[2] = mkVec(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1000, 64'd230, 1'b0, 2);
    vecs[3] = mkVec(3, 64'd123456789, 64'd987654321, 64'd1000000007, 64'd259106859, 1'b0, 3);
    vecs[4] = mkVec(0, 64'd5, 64'd6, 64'd1, 64'd0, 1'b0, 1);
    vecs[5] = mkVec(1, 64'd10, 64'd10, 64'd7, 64'd2, 1'b0, 4);

    RST       = 1'b1;
    REQ_IN    = '0;
    DATA_A_IN = '0;
    DATA_B_IN = '0;
    DATA_X_IN = '0;
    repeat (2) @(negedge CLK);
    checkOutput("rstGnt", DW'(GNT_OUT), 64'd0);
    checkOutput("rstDone", DW'(DONE_OUT), 64'd0);
    checkOutput("rstError", DW'(ERROR_OUT), 64'd0);
    checkOutput("rstData", DATA_OUT, 64'd0);
    checkOutput("rstStart", DW'(MUL_START), 64'd0);
    checkOutput("rstMulA", MUL_DATA_A, 64'd0);
    checkOutput("rstMulB", MUL_DATA_B, 64'd0);
    checkOutput("rstMulX", MUL_DATA_X, 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    $display("[TB] table-driven single requests");
    for (int i = 0; i < 6; i++) begin
      startBefore = startCount;
      applyStimulus(vecs[i]);
      waitDrain("tableDrain", 200, used);
      checkOutput("tableStartCount", DW'(startCount - startBefore), vecs[i].expErr ? 64'd0 : 64'd1);
      @(negedge CLK);
    end

    $display("[TB] pointer advances past the last winner");
    doReset();
    applyStimulus(mkVec(0, 64'd7, 64'd5, 64'd11, 64'd2, 1'b0, 1));
    waitDrain("ptrFirst", 100, used);
    @(negedge CLK);
    applyStimulus(mkVec(1, 64'd10, 64'd10, 64'd7, 64'd2, 1'b0, 1));
    applyStimulus(mkVec(0, 64'd7, 64'd5, 64'd11, 64'd2, 1'b0, 1));
    waitDrain("ptrOrder", 200, used);
    @(negedge CLK);

    $display("[TB] clients 0 and 2 together");
    doReset();
    startBefore = startCount;
    applyStimulus(mkVec(0, 64'd3, 64'd4, 64'd5, 64'd2, 1'b0, 2));
    applyStimulus(mkVec(2, 64'd6, 64'd6, 64'd7, 64'd1, 1'b0, 2));
    waitDrain("pairDrain", 200, used);
    checkOutput("pairStartCount", DW'(startCount - startBefore), 64'd2);
    @(negedge CLK);

    $display("[TB] all clients hold requests");
    doReset();
    autoDrop    = 1'b0;
    startBefore = startCount;
    for (int c = 0; c < NR; c++)
      applyStimulus(mkVec(c, 64'd2, 64'd3, 64'd5, 64'd1, 1'b0, 1));
    sb.push_back('{client: 0, data: 64'd1, err: 1'b0});
    waitDrain("holdDrain", 300, used);
    REQ_IN   = '0;
    autoDrop = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("holdNoExtraGrant", DW'(GNT_OUT), 64'd0);
    checkOutput("holdStartCount", DW'(startCount - startBefore), 64'd5);

    $display("[TB] zero modulus bypasses the multiplier");
    doReset();
    startBefore = startCount;
    applyStimulus(mkVec(1, 64'd9, 64'd9, 64'd0, 64'd0, 1'b1, 0));
    waitDrain("x0Drain", 20, used);
    checkOutput("x0Fast", DW'(used <= 2), 64'd1);
    checkOutput("x0NoStart", DW'(startCount - startBefore), 64'd0);
    @(negedge CLK);

    $display("[TB] client 3 drops its request while waiting");
    mulLatency = 8;
    DATA_A_IN[3*DW +: DW] = 64'd2;
    DATA_B_IN[3*DW +: DW] = 64'd3;
    DATA_X_IN[3*DW +: DW] = 64'd5;
    REQ_IN[3] = 1'b1;
    waitStart("dropStart", 20);
    repeat (2) @(negedge CLK);
    REQ_IN[3] = 1'b0;
    waited = 0;
    while (GNT_OUT != '0 && waited < 40) begin
      @(negedge CLK);
      waited++;
    end
    checkOutput("dropGrantReleased", DW'(GNT_OUT), 64'd0);
    checkOutput("dropDataUpdated", DATA_OUT, 64'd1);
    applyStimulus(mkVec(0, 64'd7, 64'd5, 64'd11, 64'd2, 1'b0, 2));
    waitDrain("afterDropDrain", 100, used);
    @(negedge CLK);

    $display("[TB] reset while waiting");
    mulLatency = 10;
    DATA_A_IN[2*DW +: DW] = 64'd3;
    DATA_B_IN[2*DW +: DW] = 64'd4;
    DATA_X_IN[2*DW +: DW] = 64'd5;
    REQ_IN[2] = 1'b1;
    waitStart("abortStart", 20);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    checkOutput("abortGnt", DW'(GNT_OUT), 64'd0);
    checkOutput("abortDone", DW'(DONE_OUT), 64'd0);
    checkOutput("abortStartLow", DW'(MUL_START), 64'd0);
    checkOutput("abortMulX", MUL_DATA_X, 64'd0);
    REQ_IN = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    startBefore = startCount;
    applyStimulus(mkVec(1, 64'd10, 64'd10, 64'd7, 64'd2, 1'b0, 3));
    waitDrain("afterAbortDrain", 100, used);
    checkOutput("afterAbortStartCount", DW'(startCount - startBefore), 64'd1);
    @(negedge CLK);

    $display("[TB] stray MUL_READY while idle");
    forceReady = 1'b1;
    repeat (4) @(negedge CLK);
    checkOutput("strayReadyData", DATA_OUT, 64'd2);
    checkOutput("strayReadyGnt", DW'(GNT_OUT), 64'd0);

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
